// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared counter encodings and table geometry
// Contents: ctr_e counter states, BP_IDX_W default index width,
//           BP_FALLTHRU_OFS offset from a branch to the instruction after its delay slot.
package branch_predictor_pkg;
    typedef enum logic [1:0] {BP_SNT = 2'b00, BP_WNT = 2'b01, BP_WT = 2'b10, BP_ST = 2'b11} ctr_e;
    localparam int BP_IDX_W = 6;
    localparam logic [31:0] BP_FALLTHRU_OFS = 32'd8;
endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// branch_predictor_sat_ctr: next state of a 2-bit saturating counter
// Ports: ctr_i current count, taken_i resolved outcome, ctr_o next count.
module branch_predictor_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    always_comb ctr_o = taken_i ? ((ctr_i == BP_ST)  ? ctr_i : ctr_i + 2'd1)
                                : ((ctr_i == BP_SNT) ? ctr_i : ctr_i - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, IF lookup and ID training
// Ports: clk_i, rst_ni (async active-low, clears table);
//        if_pc_i -> pred_taken_o / pred_target_o (combinational lookup);
//        upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, id_pred_taken_i, id_pred_target_i
//        -> mispredict_o / redirect_pc_o, and training at the clock edge.
// Option: BP_STATS_EN adds stat_branches_o / stat_mispred_o event counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        id_pred_taken_i,
    input  logic [31:0] id_pred_target_i,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispred_o,
`endif
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
);
    localparam int N = 2 ** IDX_W;

    logic             valid_q [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [31:0]      tgt_q   [N];
    logic [1:0]       ctr_q   [N];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit;
    logic [1:0]       ctr_d;

    assign if_idx  = if_pc_i[IDX_W+1:2];
    assign if_tag  = if_pc_i[31:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[31:IDX_W+2];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign pred_taken_o  = if_hit && ctr_q[if_idx][1];
    assign pred_target_o = pred_taken_o ? tgt_q[if_idx] : if_pc_i + 32'd4;

    // Gated by rst_ni so no flush is raised while the table is held in reset.
    assign mispredict_o  = rst_ni && upd_valid_i &&
                           ((upd_taken_i != id_pred_taken_i) ||
                            (upd_taken_i && (upd_target_i != id_pred_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + BP_FALLTHRU_OFS;

    branch_predictor_sat_ctr u_ctr (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd_taken_i),
        .ctr_o   (ctr_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= BP_WNT;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_d;
                if (upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target_i;
                ctr_q[upd_idx]   <= BP_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            stat_branches_o <= stat_branches_o + {31'd0, upd_valid_i};
            stat_mispred_o  <= stat_mispred_o + {31'd0, mispredict_o};
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing and reset
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h3000;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        id_pred_taken = 1'b0;
    logic [31:0] id_pred_target = '0;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif
    int errs = 0;
    int checks = 0;

    branch_predictor dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .id_pred_taken_i  (id_pred_taken),
        .id_pred_target_i (id_pred_target),
`ifdef BP_STATS_EN
        .stat_branches_o  (stat_branches),
        .stat_mispred_o   (stat_mispred),
`endif
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic ipt, input logic [31:0] iptgt);
        upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
        id_pred_taken = ipt; id_pred_target = iptgt;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    initial begin
        // reset state, with a write request that must be ignored
        upd(1, 32'h3010, 1, 32'h3100, 0, 0);
        look("rst", 32'h3000, 0, 32'h3004);
        chk("rst.mispredict", {31'd0, mispredict}, 0);
        tick(); tick();
        rst_n = 1'b1;
        upd(0, 0, 0, 0, 0, 0);
        look("rst.after", 32'h3010, 0, 32'h3014);
        // taken miss allocates; same-cycle lookup sees old entry
        tick();
        upd(1, 32'h3010, 1, 32'h3100, 0, 0);
        chk("alloc.mispredict", {31'd0, mispredict}, 1);
        chk("alloc.redirect", redirect_pc, 32'h3100);
        look("alloc.readold", 32'h3010, 0, 32'h3014);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("alloc.hit", 32'h3010, 1, 32'h3100);
        // three not-taken: WT->WNT->SNT->SNT
        for (int i = 0; i < 3; i++) begin
            upd(1, 32'h3010, 0, 32'h3100, 1, 32'h3100);
            chk("nt.mispredict", {31'd0, mispredict}, 1);
            chk("nt.redirect", redirect_pc, 32'h3018);
            tick();
            upd(0, 0, 0, 0, 0, 0);
            look("nt.look", 32'h3010, 0, 32'h3014);
        end
        // SNT saturated: one taken only reaches WNT, a second reaches WT
        upd(1, 32'h3010, 1, 32'h3100, 0, 0);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("snt.up1", 32'h3010, 0, 32'h3014);
        upd(1, 32'h3010, 1, 32'h3100, 0, 0);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("snt.up2", 32'h3010, 1, 32'h3100);
        // correct prediction: no flush (WT->ST)
        upd(1, 32'h3010, 1, 32'h3100, 1, 32'h3100);
        chk("ok.mispredict", {31'd0, mispredict}, 0);
        tick();
        // taken with wrong target
        upd(1, 32'h3010, 1, 32'h3200, 1, 32'h3100);
        chk("tgt.mispredict", {31'd0, mispredict}, 1);
        chk("tgt.redirect", redirect_pc, 32'h3200);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("tgt.look", 32'h3010, 1, 32'h3200);
        // correct not-taken: no flush, target kept, ST->WT still predicts taken
        upd(1, 32'h3010, 0, 32'h9999, 0, 0);
        chk("oknt.mispredict", {31'd0, mispredict}, 0);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("oknt.look", 32'h3010, 1, 32'h3200);
        // aliasing: 0x3110 shares the index of 0x3010
        upd(1, 32'h3110, 1, 32'h3400, 0, 0);
        chk("alias.mispredict", {31'd0, mispredict}, 1);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("alias.old", 32'h3010, 0, 32'h3014);
        look("alias.new", 32'h3110, 1, 32'h3400);
        // not-taken miss does not allocate
        upd(1, 32'h5000, 0, 32'h5100, 0, 0);
        chk("ntmiss.mispredict", {31'd0, mispredict}, 0);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("ntmiss.look", 32'h5000, 0, 32'h5004);
        // 32-bit wrap on fall-through arithmetic
        upd(1, 32'hFFFF_FFFC, 0, 0, 1, 32'h10);
        chk("wrap.redirect", redirect_pc, 32'h4);
        look("wrap.look", 32'hFFFF_FFFC, 0, 32'h0);
        tick();
        // same-index write/read: read returns old target
        upd(1, 32'h3110, 1, 32'h3500, 1, 32'h3400);
        chk("rw.mispredict", {31'd0, mispredict}, 1);
        look("rw.old", 32'h3110, 1, 32'h3400);
        tick();
        upd(0, 0, 0, 0, 0, 0);
        look("rw.new", 32'h3110, 1, 32'h3500);
`ifdef BP_STATS_EN
        chk("stat.branches", stat_branches, 32'd13);
        chk("stat.mispred", stat_mispred, 32'd10);
`endif
        // async reset mid-run with a pending write that must be lost
        upd(1, 32'h3200, 1, 32'h3600, 0, 0);
        rst_n = 1'b0;
        #1;
        look("arst.hit", 32'h3110, 0, 32'h3114);
        chk("arst.mispredict", {31'd0, mispredict}, 0);
`ifdef BP_STATS_EN
        chk("arst.branches", stat_branches, 0);
        chk("arst.mispred", stat_mispred, 0);
`endif
        tick();
        rst_n = 1'b1;
        upd(0, 0, 0, 0, 0, 0);
        look("arst.lost", 32'h3200, 0, 32'h3204);
        look("arst.alias", 32'h3010, 0, 32'h3014);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
